// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing stage: window limits, FSM states
// and the bipolar conversion used by the decoder.
package sc_pkg;

   localparam int SC_MAX_LOG2 = 8;
   localparam int SC_FN_W     = 18;

   typedef enum logic {SC_IDLE, SC_ACCUM} sc_state_e;

   // Two's-complement 2*count - 2^L; callers truncate to their own value width.
   function automatic logic signed [SC_FN_W-1:0] sc_bipolar(
      input logic [SC_FN_W-1:0] count,
      input logic [3:0]         L
   );
      logic [SC_FN_W-1:0] span;
      span = {{(SC_FN_W-1){1'b0}}, 1'b1} << L;
      return $signed((count << 1) - span);
   endfunction

endpackage

// File: rtl/sn_out_reg.sv
// One-entry valid/ready holding register; a result arriving while the held one
// is still unaccepted is dropped and flagged in a sticky overrun bit.
module sn_out_reg
   import sc_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clear,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   output logic              o_overrun
);

   logic [DATA_W-1:0] r_data;
   logic              r_valid;
   logic              r_overrun;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else if (i_clear) begin
         // Flush drops any held result but leaves the last data visible.
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else if (i_load) begin
         if (!r_valid || i_ready) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
         end else begin
            r_overrun <= 1'b1;
         end
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_data    = r_data;
   assign o_valid   = r_valid;
   assign o_overrun = r_overrun;

endmodule

// File: rtl/sn_window_decoder.sv
// Counts ones in a qualified stochastic bitstream over a 2^L-bit window and
// emits the count plus a unipolar or bipolar value through a valid/ready register.
module sn_window_decoder
   import sc_pkg::*;
#(
   parameter int MAX_LOG2 = SC_MAX_LOG2,
   parameter int CNT_W    = MAX_LOG2 + 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    sn_bit,
   input  logic                    sn_valid,
   input  logic [3:0]              win_log2,
   input  logic                    bipolar,
   input  logic                    clear,
   output logic [CNT_W-1:0]        out_count,
   output logic signed [CNT_W:0]   out_value,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    overrun,
   output logic                    busy
);

   sc_state_e          r_state;
   sc_state_e          w_state_nxt;
   logic [CNT_W-1:0]   r_bitcnt;
   logic [CNT_W-1:0]   r_count;
   logic [3:0]         r_L;
   logic               r_bip;

   logic [3:0]         w_L_clamp;
   logic [3:0]         w_L_cur;
   logic               w_bip_cur;
   logic [CNT_W-1:0]   w_win_m1;
   logic               w_idle;
   logic               w_last;
   logic [CNT_W-1:0]   w_final;
   logic signed [CNT_W:0] w_value;
   logic               w_done;
   logic [2*CNT_W:0]   w_q;

   assign w_idle    = (r_state == SC_IDLE);
   assign w_L_clamp = (win_log2 > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : win_log2;
   // The window parameters come straight from the inputs on the first bit only.
   assign w_L_cur   = w_idle ? w_L_clamp : r_L;
   assign w_bip_cur = w_idle ? bipolar   : r_bip;
   assign w_win_m1  = (CNT_W'(1) << r_L) - CNT_W'(1);
   assign w_last    = w_idle ? (w_L_clamp == 4'd0) : (r_bitcnt == w_win_m1);
   assign w_final   = (w_idle ? '0 : r_count) + CNT_W'(sn_bit);
   assign w_done    = sn_valid && !clear && w_last;

   assign w_value = w_bip_cur ? $signed((CNT_W+1)'(sc_bipolar(SC_FN_W'(w_final), w_L_cur)))
                              : $signed({1'b0, w_final});

   always_comb begin
      w_state_nxt = r_state;
      if (clear) begin
         w_state_nxt = SC_IDLE;
      end else if (sn_valid) begin
         w_state_nxt = w_last ? SC_IDLE : SC_ACCUM;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= SC_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bitcnt <= '0;
         r_count  <= '0;
         r_L      <= '0;
         r_bip    <= 1'b0;
      end else if (clear) begin
         r_bitcnt <= '0;
         r_count  <= '0;
      end else if (sn_valid) begin
         if (w_idle) begin
            r_L   <= w_L_clamp;
            r_bip <= bipolar;
         end
         if (w_last) begin
            r_bitcnt <= '0;
            r_count  <= '0;
         end else begin
            r_bitcnt <= r_bitcnt + CNT_W'(1);
            r_count  <= w_final;
         end
      end
   end

   sn_out_reg #(
      .DATA_W (2*CNT_W + 1)
   ) u_out_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (clear),
      .i_load    (w_done),
      .i_data    ({w_final, w_value}),
      .i_ready   (out_ready),
      .o_data    (w_q),
      .o_valid   (out_valid),
      .o_overrun (overrun)
   );

   assign out_count = w_q[2*CNT_W:CNT_W+1];
   assign out_value = $signed(w_q[CNT_W:0]);
   assign busy      = (r_state == SC_ACCUM);

endmodule

// File: tb/tb_sn_window_decoder.sv
// Scoreboard bench for sn_window_decoder: expected results are queued as each
// window's last bit is driven and compared on every output handshake.
module tb_sn_window_decoder;

   localparam int CNT_W = 9;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  sn_bit;
   logic                  sn_valid;
   logic [3:0]            win_log2;
   logic                  bipolar;
   logic                  clear;
   logic [CNT_W-1:0]      out_count;
   logic signed [CNT_W:0] out_value;
   logic                  out_valid;
   logic                  out_ready;
   logic                  overrun;
   logic                  busy;

   typedef struct {
      int cnt;
      int val;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   sn_window_decoder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sn_bit    (sn_bit),
      .sn_valid  (sn_valid),
      .win_log2  (win_log2),
      .bipolar   (bipolar),
      .clear     (clear),
      .out_count (out_count),
      .out_value (out_value),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overrun   (overrun),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one full window; optionally queues the expected result.
   task automatic run_window(input int L, input bit bip, input logic [255:0] bits, input bit push);
      int   lc;
      int   n;
      int   cnt;
      exp_t e;
      lc  = (L > 8) ? 8 : L;
      n   = 1 << lc;
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         win_log2 = 4'(L);
         bipolar  = bip;
         sn_valid = 1'b1;
         sn_bit   = bits[i];
         if (bits[i]) cnt++;
         if (i == n - 1 && push) begin
            e.cnt = cnt;
            e.val = bip ? (2 * cnt - n) : cnt;
            sb.push_back(e);
         end
         step();
      end
      sn_valid = 1'b0;
   endtask

   task automatic drive_ones(input int k);
      for (int i = 0; i < k; i++) begin
         win_log2 = 4'd3;
         bipolar  = 1'b0;
         sn_valid = 1'b1;
         sn_bit   = 1'b1;
         step();
      end
      sn_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 0, 1);
         end else begin
            e = sb.pop_front();
            chk("out_count", int'(out_count), e.cnt);
            chk("out_value", int'($signed(out_value)), e.val);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [255:0] pat;
      rst_n = 1'b0; sn_bit = 1'b0; sn_valid = 1'b0; win_log2 = 4'd3;
      bipolar = 1'b0; clear = 1'b0; out_ready = 1'b1;
      repeat (3) step();
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_count", int'(out_count), 0);
      chk("rst_value", int'($signed(out_value)), 0);
      chk("rst_overrun", int'(overrun), 0);
      chk("rst_busy", int'(busy), 0);
      rst_n = 1'b1;
      step();

      // Unipolar 8 ones; result visible right after the last edge
      pat = 256'hFF;
      run_window(3, 1'b0, pat, 1'b1);
      chk("t1_valid", int'(out_valid), 1);
      chk("t1_busy", int'(busy), 0);
      step();

      // Bipolar windows back to back
      pat = 256'h55; run_window(3, 1'b1, pat, 1'b1);
      pat = 256'h00; run_window(3, 1'b1, pat, 1'b1);
      pat = 256'hFF; run_window(3, 1'b1, pat, 1'b1);
      step();
      chk("t2_drained", int'(out_valid), 0);

      // Back-pressure: second result dropped, first held
      out_ready = 1'b0;
      pat = 256'h7; run_window(2, 1'b0, pat, 1'b1);
      pat = 256'h1; run_window(2, 1'b0, pat, 1'b0);
      chk("t3_overrun", int'(overrun), 1);
      chk("t3_valid", int'(out_valid), 1);
      step();
      chk("t3_hold", int'(out_count), 3);
      out_ready = 1'b1;
      step();
      chk("t3_released", int'(out_valid), 0);
      chk("t3_overrun_sticky", int'(overrun), 1);

      // Gaps in sn_valid freeze the window
      win_log2 = 4'd2; bipolar = 1'b0;
      sn_valid = 1'b1; sn_bit = 1'b1; step();
      sn_valid = 1'b0; sn_bit = 1'b0; step(); step();
      sn_valid = 1'b1; sn_bit = 1'b0; step();
      sn_valid = 1'b1; sn_bit = 1'b1; step();
      sn_valid = 1'b0; sn_bit = 1'b0; step();
      chk("t4_not_yet", int'(out_valid), 0);
      chk("t4_busy", int'(busy), 1);
      begin
         exp_t e;
         e.cnt = 3; e.val = 3; sb.push_back(e);
      end
      sn_valid = 1'b1; sn_bit = 1'b1; step();
      sn_valid = 1'b0;
      chk("t4_valid", int'(out_valid), 1);
      step();

      // Clamped 256-bit window, then 1-bit windows
      pat = '1;
      run_window(12, 1'b0, pat, 1'b1);
      step();
      pat = 256'h1; run_window(0, 1'b1, pat, 1'b1);
      pat = 256'h0; run_window(0, 1'b1, pat, 1'b1);
      pat = 256'h1; run_window(0, 1'b0, pat, 1'b1);
      step();

      // Reset mid-window
      drive_ones(5);
      chk("t6_busy", int'(busy), 1);
      rst_n = 1'b0; step(); rst_n = 1'b1; step();
      chk("t6_rst_valid", int'(out_valid), 0);
      chk("t6_rst_busy", int'(busy), 0);
      pat = 256'hFF; run_window(3, 1'b0, pat, 1'b1);
      step();

      // Clear mid-window
      drive_ones(5);
      clear = 1'b1; step(); clear = 1'b0;
      chk("t6_clr_busy", int'(busy), 0);
      chk("t6_clr_valid", int'(out_valid), 0);
      pat = 256'hFF; run_window(3, 1'b0, pat, 1'b1);
      step();

      // Clear on the last bit, with an overrun pending
      out_ready = 1'b0;
      pat = 256'h1;
      run_window(0, 1'b0, pat, 1'b0);
      run_window(0, 1'b0, pat, 1'b0);
      chk("t6_ovr_set", int'(overrun), 1);
      drive_ones(7);
      sn_valid = 1'b1; sn_bit = 1'b1; clear = 1'b1;
      step();
      sn_valid = 1'b0; clear = 1'b0;
      chk("t6_lastclr_valid", int'(out_valid), 0);
      chk("t6_lastclr_overrun", int'(overrun), 0);
      chk("t6_lastclr_busy", int'(busy), 0);
      out_ready = 1'b1;
      step(); step();
      chk("t6_no_result", int'(out_valid), 0);

      chk("sb_left", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
